// File: rtl/rvfpm_pkg.sv
// rvfpm_pkg: shared constants and the pipeline entry type for the rvfpm XIF timing shell
package rvfpm_pkg;
   localparam int FLEN             = 32;
   localparam int XLEN             = 32;
   localparam int NUM_FPU_REGS     = 32;
   localparam int RVFPM_X_ID_WIDTH = 4;
   localparam int RVFPM_RD_WIDTH   = $clog2(NUM_FPU_REGS);
   typedef struct packed {
      logic                        valid;
      logic [RVFPM_X_ID_WIDTH-1:0] id;
      logic [RVFPM_RD_WIDTH-1:0]   rd;
      logic                        to_xreg;
      logic [FLEN-1:0]             data;
   } rvfpm_pipe_entry_t;
endpackage

// File: rtl/rvfpm_result_fifo.sv
// rvfpm_result_fifo: show-ahead result queue with wrapping pointers and occupancy count
// Ports: ck/rst sync active-high; push_i/wdata_i write; pop_i/valid_o/rdata_o show-ahead head
//        (rdata_o forced to 0 while empty); count_o occupancy.
//        With RVFPM_ID_CHECK_EN: occ_o per-slot occupancy and mem_o raw storage for id checking.
module rvfpm_result_fifo #(
   parameter int DEPTH = 6,
   parameter int WIDTH = 8
) (
   input  logic                           ck,
   input  logic                           rst,
   input  logic                           push_i,
   input  logic [WIDTH-1:0]               wdata_i,
   input  logic                           pop_i,
   output logic                           valid_o,
   output logic [WIDTH-1:0]               rdata_o,
   output logic [$clog2(DEPTH+1)-1:0]     count_o
`ifdef RVFPM_ID_CHECK_EN
   ,
   output logic [DEPTH-1:0]               occ_o,
   output logic [DEPTH-1:0][WIDTH-1:0]    mem_o
`endif
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   logic [DEPTH-1:0][WIDTH-1:0] mem_q;
   logic [AW-1:0]               wr_q, rd_q;
   logic [CW-1:0]               cnt_q;
   function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
      return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
   endfunction
   always_ff @(posedge ck) begin
      if (push_i && !rst) mem_q[wr_q] <= wdata_i;
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) wr_q <= wrap_inc(wr_q);
         if (pop_i) rd_q <= wrap_inc(rd_q);
         cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
      end
   end
   assign valid_o = cnt_q != '0;
   assign rdata_o = valid_o ? mem_q[rd_q] : '0;
   assign count_o = cnt_q;
`ifdef RVFPM_ID_CHECK_EN
   // slot k is live when its distance from the read pointer is below the occupancy
   always_comb begin
      occ_o = '0;
      for (int k = 0; k < DEPTH; k++)
         occ_o[k] = ((k + DEPTH - int'(rd_q)) % DEPTH) < int'(cnt_q);
   end
   assign mem_o = mem_q;
`endif
endmodule

// File: rtl/rvfpm_xif_pipe.sv
// rvfpm_xif_pipe: replays precomputed FPU model results through a fixed-latency pipeline and result queue
// Ports: ck/rst sync active-high; issue_* request carrying the precomputed result, issue_ready credit-gated;
//        commit_* kills an in-pipeline id; result_* show-ahead queue head; inflight_cnt pipeline+queue
//        occupancy; id_conflict sticky duplicate-id flag.
// Optional: define RVFPM_ID_CHECK_EN to build the duplicate in-flight id checker (else id_conflict = 0).
module rvfpm_xif_pipe
   import rvfpm_pkg::*;
#(
   parameter int PIPELINE_STAGES = 4,
   parameter int RESULT_DEPTH    = 6,
   parameter int X_ID_WIDTH      = RVFPM_X_ID_WIDTH,
   parameter int X_RFW_WIDTH     = FLEN
) (
   input  logic                              ck,
   input  logic                              rst,
   input  logic                              issue_valid,
   output logic                              issue_ready,
   input  logic [X_ID_WIDTH-1:0]             issue_id,
   input  logic [4:0]                        issue_rd,
   input  logic                              issue_to_xreg,
   input  logic [X_RFW_WIDTH-1:0]            issue_data,
   input  logic                              commit_valid,
   input  logic [X_ID_WIDTH-1:0]             commit_id,
   input  logic                              commit_kill,
   output logic                              result_valid,
   input  logic                              result_ready,
   output logic [X_ID_WIDTH-1:0]             result_id,
   output logic [4:0]                        result_rd,
   output logic                              result_to_xreg,
   output logic [X_RFW_WIDTH-1:0]            result_data,
   output logic [$clog2(RESULT_DEPTH+1)-1:0] inflight_cnt,
   output logic                              id_conflict
);
   localparam int CW = $clog2(RESULT_DEPTH + 1);
   typedef struct packed {
      logic [X_ID_WIDTH-1:0]  id;
      logic [4:0]             rd;
      logic                   to_xreg;
      logic [X_RFW_WIDTH-1:0] data;
   } payload_t;
   typedef struct packed {
      logic     valid;
      payload_t p;
   } entry_t;
   localparam int PW = $bits(payload_t);
   entry_t                     stg_q [PIPELINE_STAGES];
   entry_t                     stg_d [PIPELINE_STAGES];
   logic [PIPELINE_STAGES-1:0] killed;
   logic [CW-1:0]              pipe_cnt, q_cnt;
   logic                       accept, push, pop;
   payload_t                   head;
`ifdef RVFPM_ID_CHECK_EN
   logic [RESULT_DEPTH-1:0]         q_occ;
   logic [RESULT_DEPTH-1:0][PW-1:0] q_mem;
`endif
   // every in-flight entry owns a queue slot, so the queue can never overflow
   assign issue_ready  = inflight_cnt < CW'(RESULT_DEPTH);
   assign accept       = issue_valid && issue_ready;
   assign pop          = result_valid && result_ready;
   assign push         = stg_q[PIPELINE_STAGES-1].valid && !killed[PIPELINE_STAGES-1];
   assign inflight_cnt = pipe_cnt + q_cnt;
   // a same-cycle issue enters stage 1 unkilled since only existing stages are compared
   always_comb begin
      pipe_cnt = '0;
      for (int i = 0; i < PIPELINE_STAGES; i++) begin
         killed[i] = commit_valid && commit_kill && stg_q[i].valid && stg_q[i].p.id == commit_id;
         pipe_cnt  = pipe_cnt + CW'(stg_q[i].valid);
      end
      stg_d[0] = '{valid: accept, p: '{id: issue_id, rd: issue_rd, to_xreg: issue_to_xreg, data: issue_data}};
      for (int i = 1; i < PIPELINE_STAGES; i++) begin
         stg_d[i]       = stg_q[i-1];
         stg_d[i].valid = stg_q[i-1].valid && !killed[i-1];
      end
   end
   always_ff @(posedge ck) begin
      if (rst)
         for (int i = 0; i < PIPELINE_STAGES; i++) stg_q[i] <= '0;
      else
         stg_q <= stg_d;
   end
   rvfpm_result_fifo #(.DEPTH(RESULT_DEPTH), .WIDTH(PW)) u_fifo (
      .ck      (ck),
      .rst     (rst),
      .push_i  (push),
      .wdata_i (stg_q[PIPELINE_STAGES-1].p),
      .pop_i   (pop),
      .valid_o (result_valid),
      .rdata_o (head),
      .count_o (q_cnt)
`ifdef RVFPM_ID_CHECK_EN
      ,
      .occ_o   (q_occ),
      .mem_o   (q_mem)
`endif
   );
   assign result_id      = head.id;
   assign result_rd      = head.rd;
   assign result_to_xreg = head.to_xreg;
   assign result_data    = head.data;
`ifdef RVFPM_ID_CHECK_EN
   logic     conflict_q, hit;
   payload_t qe;
   always_comb begin
      hit = 1'b0;
      qe  = '0;
      for (int i = 0; i < PIPELINE_STAGES; i++)
         hit = hit | (stg_q[i].valid && stg_q[i].p.id == issue_id);
      for (int k = 0; k < RESULT_DEPTH; k++) begin
         qe  = q_mem[k];
         hit = hit | (q_occ[k] && qe.id == issue_id);
      end
   end
   always_ff @(posedge ck) begin
      if (rst)
         conflict_q <= 1'b0;
      else if (accept && hit) begin
         conflict_q <= 1'b1;
         $error("rvfpm_xif_pipe: issue id %0d already in flight", issue_id);
      end
   end
   assign id_conflict = conflict_q;
`else
   assign id_conflict = 1'b0;
`endif
endmodule

// File: tb/tb_rvfpm_xif_pipe.sv
// tb_rvfpm_xif_pipe: directed self-checking bench for rvfpm_xif_pipe at default parameters
module tb_rvfpm_xif_pipe;
   logic        ck = 1'b0;
   logic        rst;
   logic        issue_valid, issue_ready, issue_to_xreg;
   logic [3:0]  issue_id, commit_id, result_id;
   logic [4:0]  issue_rd, result_rd;
   logic [31:0] issue_data, result_data;
   logic        commit_valid, commit_kill;
   logic        result_valid, result_ready, result_to_xreg;
   logic [2:0]  inflight_cnt;
   logic        id_conflict;
   int          n_assert = 0;
   int          n_fail   = 0;
   int          got_id[$];
   logic [31:0] got_data[$];
   int          acc;
`ifdef RVFPM_ID_CHECK_EN
   localparam logic EXP_CONF = 1'b1;
`else
   localparam logic EXP_CONF = 1'b0;
`endif
   rvfpm_xif_pipe dut (
      .ck             (ck),
      .rst            (rst),
      .issue_valid    (issue_valid),
      .issue_ready    (issue_ready),
      .issue_id       (issue_id),
      .issue_rd       (issue_rd),
      .issue_to_xreg  (issue_to_xreg),
      .issue_data     (issue_data),
      .commit_valid   (commit_valid),
      .commit_id      (commit_id),
      .commit_kill    (commit_kill),
      .result_valid   (result_valid),
      .result_ready   (result_ready),
      .result_id      (result_id),
      .result_rd      (result_rd),
      .result_to_xreg (result_to_xreg),
      .result_data    (result_data),
      .inflight_cnt   (inflight_cnt),
      .id_conflict    (id_conflict)
   );
   always #5 ck = ~ck;
   // inputs change 1ns after posedge, so the negedge view predicts the next edge's pop
   always @(negedge ck)
      if (!rst && result_valid && result_ready) begin
         got_id.push_back(int'(result_id));
         got_data.push_back(result_data);
      end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end
   task automatic step();
      @(posedge ck);
      #1;
   endtask
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask
   task automatic wait_got(input string tag, input int n, input int budget);
      int k = 0;
      while (got_id.size() < n && k < budget) begin
         step();
         k++;
      end
      chk(tag, 64'(got_id.size() >= n), 64'd1);
   endtask
   initial begin
      rst = 1'b1;
      issue_valid = 0; issue_id = 0; issue_rd = 0; issue_to_xreg = 0; issue_data = 0;
      commit_valid = 0; commit_id = 0; commit_kill = 0; result_ready = 0;
      step();
      step();
      rst = 1'b0;
      chk("rst_issue_ready", 64'(issue_ready), 64'd1);
      chk("rst_result_valid", 64'(result_valid), 64'd0);
      chk("rst_result_id", 64'(result_id), 64'd0);
      chk("rst_result_rd", 64'(result_rd), 64'd0);
      chk("rst_result_to_xreg", 64'(result_to_xreg), 64'd0);
      chk("rst_result_data", 64'(result_data), 64'd0);
      chk("rst_inflight", 64'(inflight_cnt), 64'd0);
      chk("rst_id_conflict", 64'(id_conflict), 64'd0);
      // single issue, latency 4
      result_ready = 1;
      issue_valid = 1; issue_id = 3; issue_rd = 5; issue_to_xreg = 0; issue_data = 32'h3F80_0000;
      chk("s1_ready", 64'(issue_ready), 64'd1);
      step();
      issue_valid = 0;
      chk("s1_inflight_1", 64'(inflight_cnt), 64'd1);
      for (int i = 0; i < 3; i++) begin
         chk("s1_not_yet", 64'(result_valid), 64'd0);
         step();
      end
      chk("s1_not_yet_t3", 64'(result_valid), 64'd0);
      step();
      chk("s1_valid", 64'(result_valid), 64'd1);
      chk("s1_id", 64'(result_id), 64'd3);
      chk("s1_rd", 64'(result_rd), 64'd5);
      chk("s1_data", 64'(result_data), 64'h3F80_0000);
      step();
      chk("s1_drained_valid", 64'(result_valid), 64'd0);
      chk("s1_drained_cnt", 64'(inflight_cnt), 64'd0);
      // back-to-back 10 issues
      got_id.delete(); got_data.delete();
      issue_valid = 1;
      for (int i = 0; i < 10; i++) begin
         issue_id = 4'(i); issue_data = 32'h1000 + 32'(i); issue_to_xreg = i[0];
         chk("s2_ready", 64'(issue_ready), 64'd1);
         step();
      end
      issue_valid = 0;
      wait_got("s2_wait", 10, 30);
      for (int i = 0; i < 10; i++) begin
         chk("s2_order_id", 64'(got_id[i]), 64'(i));
         chk("s2_order_data", 64'(got_data[i]), 64'h1000 + 64'(i));
      end
      step();
      chk("s2_drained", 64'(inflight_cnt), 64'd0);
      // fill with backpressure
      got_id.delete(); got_data.delete();
      result_ready = 0; acc = 0; issue_valid = 1;
      for (int i = 0; i < 10; i++) begin
         issue_id = 4'(acc); issue_data = 32'(acc);
         if (issue_ready) acc++;
         step();
      end
      issue_valid = 0;
      chk("s3_accepted", 64'(acc), 64'd6);
      chk("s3_ready_low", 64'(issue_ready), 64'd0);
      chk("s3_inflight", 64'(inflight_cnt), 64'd6);
      chk("s3_head_valid", 64'(result_valid), 64'd1);
      chk("s3_head_id", 64'(result_id), 64'd0);
      step();
      chk("s3_head_stable", 64'(result_id), 64'd0);
      chk("s3_ready_still_low", 64'(issue_ready), 64'd0);
      result_ready = 1;
      chk("s3_ready_before_pop", 64'(issue_ready), 64'd0);
      step();
      chk("s3_ready_after_pop", 64'(issue_ready), 64'd1);
      chk("s3_inflight_after_pop", 64'(inflight_cnt), 64'd5);
      wait_got("s3_wait", 6, 20);
      for (int i = 0; i < 6; i++) chk("s3_order", 64'(got_id[i]), 64'(i));
      step();
      chk("s3_drained", 64'(inflight_cnt), 64'd0);
      // kill id 2 in flight
      got_id.delete(); got_data.delete();
      issue_valid = 1;
      for (int i = 1; i <= 3; i++) begin
         issue_id = 4'(i); issue_data = 32'h4000_0000 + 32'(i);
         step();
      end
      issue_valid = 0;
      commit_valid = 1; commit_kill = 1; commit_id = 2;
      chk("s4_inflight_pre", 64'(inflight_cnt), 64'd3);
      step();
      commit_valid = 0; commit_kill = 0;
      chk("s4_inflight_post", 64'(inflight_cnt), 64'd2);
      wait_got("s4_wait", 2, 20);
      for (int i = 0; i < 6; i++) step();
      chk("s4_count", 64'(got_id.size()), 64'd2);
      chk("s4_first", 64'(got_id[0]), 64'd1);
      chk("s4_second", 64'(got_id[1]), 64'd3);
      chk("s4_second_data", 64'(got_data[1]), 64'h4000_0003);
      chk("s4_drained", 64'(inflight_cnt), 64'd0);
      // kill coinciding with issue of the same id
      got_id.delete(); got_data.delete();
      issue_valid = 1; issue_id = 5; issue_data = 32'h5555_0005;
      commit_valid = 1; commit_kill = 1; commit_id = 5;
      step();
      issue_valid = 0; commit_valid = 0; commit_kill = 0;
      chk("s5_inflight", 64'(inflight_cnt), 64'd1);
      wait_got("s5_wait", 1, 20);
      chk("s5_id", 64'(got_id[0]), 64'd5);
      chk("s5_data", 64'(got_data[0]), 64'h5555_0005);
      step();
      // reset with 3 in pipe and 2 queued
      result_ready = 0;
      issue_valid = 1;
      for (int i = 8; i <= 12; i++) begin
         issue_id = 4'(i); issue_data = 32'(i);
         step();
      end
      issue_valid = 0;
      step();
      chk("s6_inflight_pre", 64'(inflight_cnt), 64'd5);
      chk("s6_head_id", 64'(result_id), 64'd8);
      got_id.delete(); got_data.delete();
      rst = 1;
      step();
      rst = 0;
      chk("s6_valid", 64'(result_valid), 64'd0);
      chk("s6_inflight", 64'(inflight_cnt), 64'd0);
      chk("s6_ready", 64'(issue_ready), 64'd1);
      chk("s6_result_id", 64'(result_id), 64'd0);
      result_ready = 1;
      for (int i = 0; i < 6; i++) step();
      chk("s6_no_results", 64'(got_id.size()), 64'd0);
      // duplicate id in flight
      issue_valid = 1; issue_id = 7; issue_data = 32'h7;
      step();
      step();
      issue_valid = 0;
      chk("s7_conflict", 64'(id_conflict), 64'(EXP_CONF));
      wait_got("s7_wait", 2, 20);
      chk("s7_first", 64'(got_id[0]), 64'd7);
      chk("s7_second", 64'(got_id[1]), 64'd7);
      step();
      chk("s7_drained", 64'(inflight_cnt), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/rvfpm_xif_pipe.md
# rvfpm_xif_pipe

Parametrised timing shell for the rvfpm floating-point verification model: it accepts zero-latency results computed by the C++ FPU model at issue time and replays them through a configurable-depth pipeline and a result queue, presenting a CORE-V-XIF–style issue/commit/result handshake to the core. It replaces fixed, enable-gated delivery with credit-based admission, per-id kill, and result backpressure. It sits between the DPI wrapper and the core-side XIF adapter.

## Interface
- PIPELINE_STAGES, 4, execution latency in cycles (≥1)
- RESULT_DEPTH, 6, result queue entries; also the in-flight credit limit (≥1)
- X_ID_WIDTH, 4, instruction id width
- X_RFW_WIDTH, 32 (FLEN), result data width
- ck  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- issue_valid  in  1  issue request
- issue_ready  out  1  issue accepted when valid && ready
- issue_id  in  X_ID_WIDTH  instruction id
- issue_rd  in  5  destination register index
- issue_to_xreg  in  1  1: result targets integer RF, 0: FP RF
- issue_data  in  X_RFW_WIDTH  result precomputed by the model
- commit_valid  in  1  commit strobe
- commit_id  in  X_ID_WIDTH  id being committed or killed
- commit_kill  in  1  with commit_valid: discard instruction commit_id
- result_valid  out  1  head of result queue valid
- result_ready  in  1  core accepts result
- result_id / result_rd / result_to_xreg / result_data  out  X_ID_WIDTH / 5 / 1 / X_RFW_WIDTH  head entry fields
- inflight_cnt  out  $clog2(RESULT_DEPTH+1)  pipeline entries + queue occupancy
- id_conflict  out  1  sticky: issue with an id already in flight (only with RVFPM_ID_CHECK_EN)

## Operation
- Pipeline: PIPELINE_STAGES registered stages, each {valid, id, rd, to_xreg, data}; free-running, advances every cycle, never stalls.
- Admission: issue_ready = (inflight_cnt < RESULT_DEPTH); registered count only, no combinational path from result_ready or commit_* to issue_ready.
- Accepted issue enters stage 1 at the edge; final stage writes the queue at the next edge if still valid.
- Queue: show-ahead FIFO, RESULT_DEPTH entries, wrapping read/write pointers; pop on result_valid && result_ready.
- Credit cannot overflow the queue: every in-flight entry holds a reserved slot.
- inflight_cnt next = cnt + accept − pop − kill_drop; all three can occur in one cycle.
- Kill: commit_valid && commit_kill clears valid on every pipeline stage whose id == commit_id (kill_drop = number cleared, at most 1 given unique ids). Entries already in the queue are not killed. An issue accepted in the same cycle with the same id is not killed. A killed entry in the final stage is not written.
- commit_valid without kill: no effect on data path (results are speculative-free by construction).
- Results leave in issue order; ids do not reorder.
- Reset mid-operation: all stage valids, queue pointers, and counters cleared at the edge; contents discarded, no result emitted.

## Timing
- Reset values: issue_ready 1, result_valid 0, result_id/rd/to_xreg/data 0, inflight_cnt 0, id_conflict 0.
- Latency: issue accepted on edge t → result_valid high after edge t+PIPELINE_STAGES (queue empty).
- Throughput 1/cycle sustained only if RESULT_DEPTH ≥ PIPELINE_STAGES+2 and result_ready held high.
- result_* held stable while result_valid && !result_ready.
- Queue full and pipeline empty: issue_ready 0 until a pop is registered (ready rises the cycle after the pop edge).

## Configuration
- RVFPM_ID_CHECK_EN defined: on accept, compare issue_id against all valid pipeline and queue entries; on match, set id_conflict (sticky until rst) and emit $error; entry still accepted.
- Undefined: comparator absent, id_conflict tied 0.

## Structure
- rvfpm_pkg: FLEN, XLEN, NUM_FPU_REGS constants; typedef struct rvfpm_pipe_entry_t {valid, id, rd, to_xreg, data} parametrised via package-level widths.
- One sub-module: rvfpm_result_fifo (show-ahead, depth RESULT_DEPTH, count output). Pipeline stages and credit logic stay in rvfpm_xif_pipe.

## Test plan
- Single issue id=3, data=0x3F800000, result_ready=1 → result_valid exactly 4 cycles after accept, result_id=3, result_data=0x3F800000, inflight_cnt back to 0.
- Back-to-back 10 issues ids 0..9, result_ready=1, defaults → one issue accepted per cycle, results in order 0..9, issue_ready never drops.
- result_ready=0, issue continuously → exactly 6 accepted, issue_ready 0, inflight_cnt=6; raise result_ready → ids pop in order, issue_ready rises one cycle after first pop.
- Issue ids 1,2,3 consecutively; kill id 2 two cycles later → results 1 then 3 only, inflight_cnt decremented by the kill.
- Kill id 5 in same cycle as issue of id 5 → id 5 result still delivered.
- Assert rst with 3 entries in pipe and 2 in queue → next cycle result_valid 0, inflight_cnt 0, issue_ready 1; with RVFPM_ID_CHECK_EN, issuing id 7 twice while in flight sets id_conflict=1.
